mmips_wb_arbiter: RTL and testbench

//  Write-side front end of the 32x32 register file: merges single-cycle ALU results and

---
 rtl/mmips_wb_arbiter_pkg.sv | 19 +
 rtl/mmips_wb_fifo.sv | 61 ++++++
 rtl/mmips_wb_arbiter.sv | 92 +++++++++
 tb/tb_mmips_wb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mmips_wb_arbiter_pkg.sv
// Shared register-file write-back types and widths for the mmips write-side front end.
package mmips_wb_arbiter_pkg;

    localparam int unsigned DWORD = 32;
    localparam int unsigned RADDR = 5;
    localparam int unsigned NREGS = 32;

    typedef struct packed {
        logic [RADDR-1:0] addr;
        logic [DWORD-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/mmips_wb_fifo.sv
// Synchronous load-result FIFO: registered head, no fall-through, pointers wrap modulo DEPTH.
module mmips_wb_fifo
    import mmips_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  wb_entry_t data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic [AW:0] count_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mmips_wb_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, buffered loads drain in gaps,
// and a pending-load scoreboard reports one busy bit per register.
module mmips_wb_arbiter
    import mmips_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [RADDR-1:0] alu_addr,
    input  logic [DWORD-1:0] alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [RADDR-1:0] ld_addr,
    input  logic [DWORD-1:0] ld_data,
    input  logic             issue_valid,
    input  logic [RADDR-1:0] issue_addr,
    output logic             w,
    output logic [RADDR-1:0] w_addr_reg,
    output logic [DWORD-1:0] w_data_reg,
    output logic [NREGS-1:0] busy_mask,
    output logic [AW:0]      fifo_count
);

    wb_entry_t        head, ld_entry, sel;
    wb_src_e          src;
    logic             fifo_empty, fifo_full, pop;
    logic             w_q;
    wb_entry_t        wb_q;
    logic [NREGS-1:0] busy_q, busy_d;

    assign ld_entry = '{addr: ld_addr, data: ld_data};

    mmips_wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ld_valid && ld_ready),
        .data_i  (ld_entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
    assign ld_ready = !fifo_full;

    always_comb begin
        src = SRC_NONE;
        sel = head;
        if (alu_valid) begin
            src = SRC_ALU;
            sel = '{addr: alu_addr, data: alu_data};
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end
    end

    assign pop = (src == SRC_FIFO);

    // Issue is applied after the pop-clear so a same-cycle set of the same bit wins.
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[head.addr] = 1'b0;
        if (issue_valid) busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q    <= 1'b0;
            wb_q   <= '0;
            busy_q <= '0;
        end else begin
            w_q    <= (src != SRC_NONE) && (sel.addr != '0);
            if (src != SRC_NONE) wb_q <= sel;
            busy_q <= busy_d;
        end
    end

    assign w          = w_q;
    assign w_addr_reg = wb_q.addr;
    assign w_data_reg = wb_q.data;
    assign busy_mask  = busy_q;

endmodule

// File: tb/tb_mmips_wb_arbiter.sv
// Directed bench for mmips_wb_arbiter: reset, lone load, contention, r0, set/clear race, mid-flight reset.
module tb_mmips_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        w;
    logic [4:0]  w_addr_reg;
    logic [31:0] w_data_reg;
    logic [31:0] busy_mask;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    mmips_wb_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .w           (w),
        .w_addr_reg  (w_addr_reg),
        .w_data_reg  (w_data_reg),
        .busy_mask   (busy_mask),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        issue_valid = 1'b0; issue_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h1234_5678;
        step(); step();
        rst = 1'b0; ld_valid = 1'b0;
        n_tests++; if (w !== 1'b0) begin n_fail++; $display("FAIL reset_w: got %0b want 0", w); end
        n_tests++; if (w_addr_reg !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", w_addr_reg); end
        n_tests++; if (w_data_reg !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", w_data_reg); end
        n_tests++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", ld_ready); end
    endtask

    task automatic test_lone_load();
        idle_inputs();
        issue_valid = 1'b1; issue_addr = 5'd5;
        step();
        issue_valid = 1'b0;
        n_tests++; if (busy_mask !== 32'h0000_0020) begin n_fail++; $display("FAIL lone_busy_set: got %h want 00000020", busy_mask); end
        ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 32'hDEAD_BEEF;
        step();
        ld_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL lone_count: got %0d want 1", fifo_count); end
        n_tests++; if (w !== 1'b0) begin n_fail++; $display("FAIL lone_no_fallthrough: got w=%0b want 0", w); end
        n_tests++; if (busy_mask !== 32'h0000_0020) begin n_fail++; $display("FAIL lone_busy_held: got %h want 00000020", busy_mask); end
        step();
        n_tests++; if (w !== 1'b1) begin n_fail++; $display("FAIL lone_w: got %0b want 1", w); end
        n_tests++; if (w_addr_reg !== 5'd5) begin n_fail++; $display("FAIL lone_addr: got %0d want 5", w_addr_reg); end
        n_tests++; if (w_data_reg !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lone_data: got %h want deadbeef", w_data_reg); end
        n_tests++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL lone_busy_clr: got %h want 0", busy_mask); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL lone_count_drain: got %0d want 0", fifo_count); end
        step();
        n_tests++; if (w !== 1'b0) begin n_fail++; $display("FAIL lone_idle_w: got %0b want 0", w); end
        n_tests++; if (w_addr_reg !== 5'd5) begin n_fail++; $display("FAIL lone_idle_hold: got %0d want 5", w_addr_reg); end
    endtask

    task automatic test_contention();
        int k;
        logic rdy;
        idle_inputs();
        for (int r = 8; r < 12; r++) begin
            issue_valid = 1'b1; issue_addr = 5'(r);
            step();
        end
        issue_valid = 1'b0;
        n_tests++; if (busy_mask !== 32'h0000_0F00) begin n_fail++; $display("FAIL cont_busy_set: got %h want 00000f00", busy_mask); end
        k = 0;
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1'b1; alu_addr = 5'(c + 1); alu_data = 32'hA000_0000 + 32'(c + 1);
            if (k < 4) begin
                ld_valid = 1'b1; ld_addr = 5'(8 + k); ld_data = 32'hB000_0000 + 32'(8 + k);
            end else begin
                ld_valid = 1'b1; ld_addr = 5'd12; ld_data = 32'h0BAD_0BAD;
            end
            if (c >= 4) begin
                n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL cont_ready_full c=%0d: got %0b want 0", c, ld_ready); end
            end
            rdy = ld_ready;
            step();
            if (ld_valid && rdy) k++;
            n_tests++; if (w !== 1'b1 || w_addr_reg !== 5'(c + 1) || w_data_reg !== 32'hA000_0000 + 32'(c + 1)) begin
                n_fail++; $display("FAIL cont_alu c=%0d: got w=%0b addr=%0d data=%h want w=1 addr=%0d data=%h",
                                   c, w, w_addr_reg, w_data_reg, c + 1, 32'hA000_0000 + 32'(c + 1));
            end
        end
        idle_inputs();
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL cont_count_full: got %0d want 4", fifo_count); end
        for (int d = 0; d < 4; d++) begin
            step();
            n_tests++; if (w !== 1'b1 || w_addr_reg !== 5'(8 + d) || w_data_reg !== 32'hB000_0000 + 32'(8 + d)) begin
                n_fail++; $display("FAIL cont_load d=%0d: got w=%0b addr=%0d data=%h want w=1 addr=%0d data=%h",
                                   d, w, w_addr_reg, w_data_reg, 8 + d, 32'hB000_0000 + 32'(8 + d));
            end
        end
        step();
        n_tests++; if (w !== 1'b0) begin n_fail++; $display("FAIL cont_tail_w: got %0b want 0", w); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL cont_tail_count: got %0d want 0", fifo_count); end
        n_tests++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL cont_tail_busy: got %h want 0", busy_mask); end
    endtask

    task automatic test_r0();
        idle_inputs();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1111_1111;
        issue_valid = 1'b1; issue_addr = 5'd0;
        step();
        idle_inputs();
        n_tests++; if (w !== 1'b0) begin n_fail++; $display("FAIL r0_alu_w: got %0b want 0", w); end
        n_tests++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL r0_busy: got %h want 0", busy_mask); end
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h2222_2222;
        step();
        idle_inputs();
        n_tests++; if (w !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL r0_push: got w=%0b count=%0d want w=0 count=1", w, fifo_count); end
        step();
        n_tests++; if (w !== 1'b0) begin n_fail++; $display("FAIL r0_load_w: got %0b want 0", w); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL r0_drain: got %0d want 0", fifo_count); end
    endtask

    task automatic test_race();
        idle_inputs();
        issue_valid = 1'b1; issue_addr = 5'd7;
        step();
        idle_inputs();
        ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h7777_0001;
        step();
        idle_inputs();
        issue_valid = 1'b1; issue_addr = 5'd7;
        step();
        idle_inputs();
        n_tests++; if (w !== 1'b1 || w_addr_reg !== 5'd7) begin n_fail++; $display("FAIL race_write: got w=%0b addr=%0d want w=1 addr=7", w, w_addr_reg); end
        n_tests++; if (busy_mask !== 32'h0000_0080) begin n_fail++; $display("FAIL race_set_wins: got %h want 00000080", busy_mask); end
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h7777_0002;
        step();
        idle_inputs();
        n_tests++; if (w !== 1'b1 || w_data_reg !== 32'h7777_0002) begin n_fail++; $display("FAIL race_alu: got w=%0b data=%h want w=1 data=77770002", w, w_data_reg); end
        n_tests++; if (busy_mask !== 32'h0000_0080) begin n_fail++; $display("FAIL race_alu_keeps_busy: got %h want 00000080", busy_mask); end
        ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h7777_0003;
        step();
        idle_inputs();
        step();
        n_tests++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL race_final_clr: got %h want 0", busy_mask); end
    endtask

    task automatic test_midflight_reset();
        idle_inputs();
        issue_valid = 1'b1; issue_addr = 5'd20;
        step();
        for (int c = 0; c < 3; c++) begin
            issue_valid = 1'b0;
            alu_valid = 1'b1; alu_addr = 5'(c + 1); alu_data = 32'(c);
            ld_valid = 1'b1; ld_addr = 5'(20 + c); ld_data = 32'hC000_0000 + 32'(c);
            step();
        end
        idle_inputs();
        n_tests++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_count3: got %0d want 3", fifo_count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_count0: got %0d want 0", fifo_count); end
        n_tests++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL mid_busy: got %h want 0", busy_mask); end
        n_tests++; if (w !== 1'b0) begin n_fail++; $display("FAIL mid_w: got %0b want 0", w); end
        for (int c = 0; c < 4; c++) begin
            step();
            n_tests++; if (w !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_stale c=%0d: got w=%0b count=%0d want w=0 count=0", c, w, fifo_count); end
        end
    endtask

    initial begin
        test_reset();
        test_lone_load();
        test_contention();
        test_r0();
        test_race();
        test_midflight_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
